// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM state encoding and
// the port-index constants used by the arbiter and its pick sub-block.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_e;

    localparam int P_CPU = 0;  // pipeline MEM stage
    localparam int P_DMA = 1;  // loader / DMA engine

endpackage

// File: rtl/dmem_arb_pick.sv
// 2-way pick: the port named by ptr_i wins when both request, otherwise
// whichever port requests is granted. Output is one-hot or zero.
module dmem_arb_pick (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    logic other;
    assign other = ~ptr_i;

    // Preferred port first, then the other one.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[ptr_i])
            gnt_o[ptr_i] = 1'b1;
        else if (req_i[other])
            gnt_o[other] = 1'b1;
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one single-port synchronous data memory between the CPU MEM stage
// (port 0) and the DMA/loader (port 1). Grants one access per cycle, muxes
// the winner onto the memory port and steers the 1-cycle read response back.
// Locked bursts keep ownership for up to MAX_BURST consecutive grants.
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking; without
// it port 0 always wins ties and no pointer register exists.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_lock,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_lock,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       rvalid_q;
    logic [1:0]       req, lock, pick_gnt, gnt;
    logic             ptr, held, own, win, xfer, sel, sel_we;

`ifdef DMEM_ARB_RR_EN
    logic rr_q, rr_d;
    assign ptr = rr_q;
`else
    assign ptr = 1'(P_CPU);
`endif

    assign req     = {p1_req, p0_req};
    assign lock    = {p1_lock, p0_lock};
    assign cnt_inc = cnt_q + CNT_W'(1);

    dmem_arb_pick u_pick (
        .req_i (req),
        .ptr_i (ptr),
        .gnt_o (pick_gnt)
    );

    // Lock owner keeps the port while it asserts req&lock; otherwise arbitrate.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt     = 2'b00;
        own     = (state_q == LOCK1);
        win     = pick_gnt[P_DMA];
        held    = ((state_q == LOCK0) && p0_req && p0_lock) ||
                  ((state_q == LOCK1) && p1_req && p1_lock);
`ifdef DMEM_ARB_RR_EN
        rr_d    = rr_q;
`endif
        if (!rst) begin
            if (held) begin
                gnt[own] = 1'b1;
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                    // Forced release: the other port is preferred next tie.
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef DMEM_ARB_RR_EN
                    rr_d    = ~own;
`endif
                end else begin
                    cnt_d = cnt_inc;
                end
            end else begin
                gnt     = pick_gnt;
                state_d = IDLE;
                cnt_d   = '0;
                if (|pick_gnt) begin
`ifdef DMEM_ARB_RR_EN
                    rr_d = ~win;
`endif
                    // A 1-deep burst is already exhausted by this grant.
                    if (lock[win] && (MAX_BURST > 1)) begin
                        state_d = win ? LOCK1 : LOCK0;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
        end
    end

    // FSM, burst counter and tie pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef DMEM_ARB_RR_EN
            rr_q    <= 1'(P_CPU);
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef DMEM_ARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // Remember which port issued a read so the response is steered back.
    always_ff @(posedge clk) begin
        if (rst)
            rvalid_q <= 2'b00;
        else
            rvalid_q <= gnt & ~{p1_we, p0_we};
    end

    assign p0_gnt = gnt[P_CPU];
    assign p1_gnt = gnt[P_DMA];
    assign xfer   = |gnt;
    assign sel    = gnt[P_DMA];
    assign sel_we = sel ? p1_we : p0_we;

    assign mem_addr  = xfer ? (sel ? p1_addr : p0_addr) : '0;
    assign mem_wdata = xfer ? (sel ? p1_wdata : p0_wdata) : '0;
    assign mem_read  = xfer & ~sel_we;
    assign mem_write = xfer & sel_we;

    // Masking with rst drops a response whose read was in flight at reset.
    assign p0_rvalid = rvalid_q[P_CPU] & ~rst;
    assign p1_rvalid = rvalid_q[P_DMA] & ~rst;
    assign p0_rdata  = mem_rdata;
    assign p1_rdata  = mem_rdata;

endmodule
